riscv_id: RTL and testbench

Instruction decode stage of the RISC-V pipeline; the producer side of the `riscv_ex` operand interface. It does the following:

- Accepts a 32-bit instruction from fetch.
- Reads the integer register file, with write-through of writeback data and forwarding from the EX output register.
- Decodes OP/OP-IMM/LUI into the `rdi/a/b/shamt/funct3/invertb` bundle, registered for `riscv_ex`.
- Stalls fetch on RAW hazards that cannot yet be forwarded.

---
 rtl/riscv_id_pkg.sv | 65 ++++++
 rtl/riscv_regfile.sv | 53 +++++
 rtl/riscv_id.sv | 224 ++++++++++++++++++++++
 tb/tb_riscv_id.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_id_pkg.sv
// Shared ISA constants, decode types and small helpers for the RISC-V
// instruction decode stage and its register file.
package riscv_id_pkg;

   localparam int XLEN = 32;

   // Major opcodes handled by the decode stage
   localparam logic [6:0] OPCODE_OP     = 7'b0110011;
   localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPCODE_LUI    = 7'b0110111;

   // ALU function encodings shared with riscv_ex
   localparam logic [2:0] FUNCT3_ADD  = 3'b000;
   localparam logic [2:0] FUNCT3_SLL  = 3'b001;
   localparam logic [2:0] FUNCT3_SLT  = 3'b010;
   localparam logic [2:0] FUNCT3_SLTU = 3'b011;
   localparam logic [2:0] FUNCT3_XOR  = 3'b100;
   localparam logic [2:0] FUNCT3_SRL  = 3'b101;
   localparam logic [2:0] FUNCT3_OR   = 3'b110;
   localparam logic [2:0] FUNCT3_AND  = 3'b111;

   typedef enum logic [1:0] {
      CLS_OP      = 2'd0,
      CLS_OP_IMM  = 2'd1,
      CLS_LUI     = 2'd2,
      CLS_ILLEGAL = 2'd3
   } instr_class_e;

   // Operand bundle handed to riscv_ex
   typedef struct packed {
      logic [4:0]      rdi;
      logic [XLEN-1:0] a;
      logic [XLEN-1:0] b;
      logic [4:0]      shamt;
      logic [2:0]      funct3;
      logic            invertb;
   } id_bundle_t;

   // A bubble writes zero to x0 with an ADD, which is architecturally inert
   localparam id_bundle_t ID_BUBBLE = '{
      rdi:     5'd0,
      a:       32'd0,
      b:       32'd0,
      shamt:   5'd0,
      funct3:  FUNCT3_ADD,
      invertb: 1'b0
   };

   function automatic instr_class_e classify(input logic [6:0] opcode);
      instr_class_e cls;
      case (opcode)
         OPCODE_OP:     cls = CLS_OP;
         OPCODE_OP_IMM: cls = CLS_OP_IMM;
         OPCODE_LUI:    cls = CLS_LUI;
         default:       cls = CLS_ILLEGAL;
      endcase
      return cls;
   endfunction

   // SLL/SRL/SRA (and immediate forms) take their amount via shamt
   function automatic logic is_shift(input logic [2:0] f3);
      return (f3 == FUNCT3_SLL) || (f3 == FUNCT3_SRL);
   endfunction

endpackage

// File: rtl/riscv_regfile.sv
// 32x32 integer register file: two read ports, one write port, x0 tied to
// zero, and write-through so a same-cycle read sees the value being written.
module riscv_regfile
   import riscv_id_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic [4:0]      raddr1,
   input  logic [4:0]      raddr2,
   output logic [XLEN-1:0] rdata1,
   output logic [XLEN-1:0] rdata2,
   input  logic            we,
   input  logic [4:0]      waddr,
   input  logic [XLEN-1:0] wdata
);

   logic [XLEN-1:0] regs_r [32];
   logic            wr_s;

   // Writes to x0 are dropped and reset takes precedence over writeback
   assign wr_s = we && (waddr != 5'd0) && !rst;

   // Register array: cleared on reset, otherwise written on a valid strobe
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 32; i++) begin
            regs_r[i] <= {XLEN{1'b0}};
         end
      end else if (wr_s) begin
         regs_r[waddr] <= wdata;
      end
   end

   // Read ports with x0 hardwiring and write-through of the incoming value
   always_comb begin
      if (raddr1 == 5'd0) begin
         rdata1 = {XLEN{1'b0}};
      end else if (wr_s && (waddr == raddr1)) begin
         rdata1 = wdata;
      end else begin
         rdata1 = regs_r[raddr1];
      end

      if (raddr2 == 5'd0) begin
         rdata2 = {XLEN{1'b0}};
      end else if (wr_s && (waddr == raddr2)) begin
         rdata2 = wdata;
      end else begin
         rdata2 = regs_r[raddr2];
      end
   end

endmodule

// File: rtl/riscv_id.sv
// Instruction decode stage: reads operands (with forwarding from EX and
// writeback), detects RAW hazards that cannot yet be forwarded, and registers
// the operand bundle consumed by riscv_ex.
module riscv_id
   import riscv_id_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] instr,
   input  logic        instr_valid,
   output logic        stall,
   input  logic        wb_en,
   input  logic [4:0]  wb_rd,
   input  logic [31:0] wb_data,
   input  logic [4:0]  ex_rd,
   input  logic [31:0] ex_result,
   input  logic        ex_memfetch,
   output logic [4:0]  rdi,
   output logic [31:0] a,
   output logic [31:0] b,
   output logic [4:0]  shamt,
   output logic [2:0]  funct3,
   output logic        invertb,
   output logic        illegal
);

   logic [6:0]   opcode_s;
   logic [4:0]   rs1_s;
   logic [4:0]   rs2_s;
   logic [4:0]   rd_s;
   logic [2:0]   f3_s;
   instr_class_e cls_s;
   logic         use_rs1_s;
   logic         use_rs2_s;
   logic [31:0]  rf_rs1_s;
   logic [31:0]  rf_rs2_s;
   logic [31:0]  rs1_val_s;
   logic [31:0]  rs2_val_s;
   logic         haz1_s;
   logic         haz2_s;
   logic         stall_s;
   logic         accept_s;
   id_bundle_t   dec_s;
   id_bundle_t   nxt_s;
   logic         illegal_nxt_s;
   id_bundle_t   bundle_r;
   logic         illegal_r;

   assign opcode_s = instr[6:0];
   assign rd_s     = instr[11:7];
   assign f3_s     = instr[14:12];
   assign rs1_s    = instr[19:15];
   assign rs2_s    = instr[24:20];
   assign cls_s    = classify(opcode_s);

   riscv_regfile u_regfile (
      .clk    (clk),
      .rst    (rst),
      .raddr1 (rs1_s),
      .raddr2 (rs2_s),
      .rdata1 (rf_rs1_s),
      .rdata2 (rf_rs2_s),
      .we     (wb_en),
      .waddr  (wb_rd),
      .wdata  (wb_data)
   );

   // A source conflicts with the op still in EX's input latch, or with an
   // EX result that is a pending memory fetch and therefore not yet known
   function automatic logic raw_hazard(
      input logic [4:0] rs,
      input logic [4:0] rdi_q,
      input logic [4:0] exrd,
      input logic       memfetch
   );
      return ((rs == rdi_q) && (rdi_q != 5'd0)) ||
             ((rs == exrd) && (exrd != 5'd0) && memfetch);
   endfunction

   // EX output is the youngest value; the register file already folds in
   // writeback through its write-through path
   function automatic logic [31:0] fwd(
      input logic [4:0]  idx,
      input logic [31:0] rf_val,
      input logic [4:0]  exrd,
      input logic [31:0] exres
   );
      logic [31:0] v;
      if (idx == 5'd0) begin
         v = 32'd0;
      end else if (idx == exrd) begin
         v = exres;
      end else begin
         v = rf_val;
      end
      return v;
   endfunction

   // Which source registers the current instruction really reads
   always_comb begin
      use_rs1_s = 1'b0;
      use_rs2_s = 1'b0;
      case (cls_s)
         CLS_OP: begin
            use_rs1_s = 1'b1;
            use_rs2_s = 1'b1;
         end
         CLS_OP_IMM: begin
            use_rs1_s = 1'b1;
            use_rs2_s = 1'b0;
         end
         default: begin
            use_rs1_s = 1'b0;
            use_rs2_s = 1'b0;
         end
      endcase
   end

   // Combinational RAW hazard detection driving the fetch stall
   always_comb begin
      haz1_s = 1'b0;
      haz2_s = 1'b0;
      if (use_rs1_s) begin
         haz1_s = raw_hazard(rs1_s, bundle_r.rdi, ex_rd, ex_memfetch);
      end else begin
         haz1_s = 1'b0;
      end
      if (use_rs2_s) begin
         haz2_s = raw_hazard(rs2_s, bundle_r.rdi, ex_rd, ex_memfetch);
      end else begin
         haz2_s = 1'b0;
      end
      stall_s = instr_valid && (haz1_s || haz2_s);
   end

   assign stall     = stall_s;
   assign rs1_val_s = fwd(rs1_s, rf_rs1_s, ex_rd, ex_result);
   assign rs2_val_s = fwd(rs2_s, rf_rs2_s, ex_rd, ex_result);

   // Decode the instruction into the EX operand bundle
   always_comb begin
      dec_s     = ID_BUBBLE;
      dec_s.rdi = rd_s;
      case (cls_s)
         CLS_OP: begin
            dec_s.a      = rs1_val_s;
            dec_s.funct3 = f3_s;
            if (is_shift(f3_s)) begin
               dec_s.b     = 32'd0;
               dec_s.shamt = rs2_val_s[4:0];
            end else begin
               dec_s.b     = rs2_val_s;
               dec_s.shamt = 5'd0;
            end
            // instr[30] selects SUB over ADD and SRA over SRL
            if ((f3_s == FUNCT3_ADD) || (f3_s == FUNCT3_SRL)) begin
               dec_s.invertb = instr[30];
            end else begin
               dec_s.invertb = 1'b0;
            end
         end
         CLS_OP_IMM: begin
            dec_s.a      = rs1_val_s;
            dec_s.funct3 = f3_s;
            if (is_shift(f3_s)) begin
               dec_s.b     = 32'd0;
               dec_s.shamt = instr[24:20];
               // there is no SUBI, so only SRAI honours instr[30]
               if (f3_s == FUNCT3_SRL) begin
                  dec_s.invertb = instr[30];
               end else begin
                  dec_s.invertb = 1'b0;
               end
            end else begin
               dec_s.b       = {{20{instr[31]}}, instr[31:20]};
               dec_s.shamt   = 5'd0;
               dec_s.invertb = 1'b0;
            end
         end
         CLS_LUI: begin
            dec_s.a       = 32'd0;
            dec_s.b       = {instr[31:12], 12'd0};
            dec_s.funct3  = FUNCT3_ADD;
            dec_s.shamt   = 5'd0;
            dec_s.invertb = 1'b0;
         end
         default: begin
            dec_s = ID_BUBBLE;
         end
      endcase
   end

   // Choose between the decoded bundle and a bubble; flag illegal opcodes
   always_comb begin
      accept_s = instr_valid && !stall_s;
      if (accept_s && (cls_s != CLS_ILLEGAL)) begin
         nxt_s         = dec_s;
         illegal_nxt_s = 1'b0;
      end else begin
         nxt_s         = ID_BUBBLE;
         illegal_nxt_s = accept_s && (cls_s == CLS_ILLEGAL);
      end
   end

   // Output register towards EX
   always_ff @(posedge clk) begin
      if (rst) begin
         bundle_r  <= ID_BUBBLE;
         illegal_r <= 1'b0;
      end else begin
         bundle_r  <= nxt_s;
         illegal_r <= illegal_nxt_s;
      end
   end

   assign rdi     = bundle_r.rdi;
   assign a       = bundle_r.a;
   assign b       = bundle_r.b;
   assign shamt   = bundle_r.shamt;
   assign funct3  = bundle_r.funct3;
   assign invertb = bundle_r.invertb;
   assign illegal = illegal_r;

endmodule

// File: tb/tb_riscv_id.sv
// Self-checking bench for riscv_id: expected bundles are queued as stimulus
// is driven and compared against the registered outputs after each edge.
module tb_riscv_id;

   typedef struct packed {
      logic [4:0]  rdi;
      logic [31:0] a;
      logic [31:0] b;
      logic [4:0]  shamt;
      logic [2:0]  funct3;
      logic        invertb;
      logic        illegal;
   } exp_t;

   logic        clk;
   logic        rst;
   logic [31:0] instr;
   logic        instr_valid;
   logic        stall;
   logic        wb_en;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic [4:0]  ex_rd;
   logic [31:0] ex_result;
   logic        ex_memfetch;
   logic [4:0]  rdi;
   logic [31:0] a;
   logic [31:0] b;
   logic [4:0]  shamt;
   logic [2:0]  funct3;
   logic        invertb;
   logic        illegal;

   int    tests_run = 0;
   int    tests_failed = 0;
   exp_t  exp_q[$];
   string name_q[$];

   riscv_id dut (
      .clk         (clk),
      .rst         (rst),
      .instr       (instr),
      .instr_valid (instr_valid),
      .stall       (stall),
      .wb_en       (wb_en),
      .wb_rd       (wb_rd),
      .wb_data     (wb_data),
      .ex_rd       (ex_rd),
      .ex_result   (ex_result),
      .ex_memfetch (ex_memfetch),
      .rdi         (rdi),
      .a           (a),
      .b           (b),
      .shamt       (shamt),
      .funct3      (funct3),
      .invertb     (invertb),
      .illegal     (illegal)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3,
                                         input logic [4:0] rd);
      return {f7, rs2, rs1, f3, rd, 7'b0110011};
   endfunction

   function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                         input logic [2:0] f3, input logic [4:0] rd);
      return {imm, rs1, f3, rd, 7'b0010011};
   endfunction

   function automatic logic [31:0] enc_lui(input logic [19:0] imm, input logic [4:0] rd);
      return {imm, rd, 7'b0110111};
   endfunction

   task automatic expect_out(input string nm, input logic [4:0] e_rdi, input logic [31:0] e_a,
                             input logic [31:0] e_b, input logic [4:0] e_sh,
                             input logic [2:0] e_f3, input logic e_inv, input logic e_ill);
      exp_t e;
      e.rdi = e_rdi; e.a = e_a; e.b = e_b; e.shamt = e_sh;
      e.funct3 = e_f3; e.invertb = e_inv; e.illegal = e_ill;
      exp_q.push_back(e);
      name_q.push_back(nm);
   endtask

   task automatic expect_bubble(input string nm);
      expect_out(nm, 5'd0, 32'd0, 32'd0, 5'd0, 3'd0, 1'b0, 1'b0);
   endtask

   // One clock edge, then pop the oldest expectation and compare
   task automatic step();
      exp_t  e;
      exp_t  obs;
      string nm;
      @(posedge clk);
      #1;
      obs = '{rdi, a, b, shamt, funct3, invertb, illegal};
      tests_run++;
      if (exp_q.size() == 0) begin
         tests_failed++;
         $display("FAIL scoreboard_empty: no expectation queued at time %0t", $time);
      end else begin
         e  = exp_q.pop_front();
         nm = name_q.pop_front();
         if (obs !== e) begin
            tests_failed++;
            $display("FAIL %s: got rdi=%0d a=%h b=%h shamt=%0d f3=%0d inv=%b ill=%b, expected rdi=%0d a=%h b=%h shamt=%0d f3=%0d inv=%b ill=%b",
                     nm, obs.rdi, obs.a, obs.b, obs.shamt, obs.funct3, obs.invertb, obs.illegal,
                     e.rdi, e.a, e.b, e.shamt, e.funct3, e.invertb, e.illegal);
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; instr = 32'd0; instr_valid = 1'b0;
      wb_en = 1'b0; wb_rd = 5'd0; wb_data = 32'd0;
      ex_rd = 5'd0; ex_result = 32'd0; ex_memfetch = 1'b0;
      expect_bubble("reset0"); step();
      expect_bubble("reset1"); step();
      rst = 1'b0;
      #1;
      tests_run++;
      if (stall !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_stall: stall=%b expected 0", stall);
      end
      expect_bubble("idle"); step();
   endtask

   task automatic test_alu();
      // x1 = 40 via writeback while idle
      wb_en = 1'b1; wb_rd = 5'd1; wb_data = 32'd40;
      expect_bubble("wb_x1"); step();
      wb_en = 1'b0;
      instr = enc_i(12'd2, 5'd1, 3'b000, 5'd4); instr_valid = 1'b1;
      expect_out("addi", 5'd4, 32'd40, 32'd2, 5'd0, 3'd0, 1'b0, 1'b0); step();
      // x3 = 5 arrives by write-through in the same cycle
      wb_en = 1'b1; wb_rd = 5'd3; wb_data = 32'd5;
      instr = enc_r(7'b0100000, 5'd3, 5'd1, 3'b000, 5'd2);
      expect_out("sub", 5'd2, 32'd40, 32'd5, 5'd0, 3'd0, 1'b1, 1'b0); step();
      wb_rd = 5'd5; wb_data = 32'd3;
      instr = enc_i(12'd2, 5'd5, 3'b001, 5'd7);
      expect_out("slli", 5'd7, 32'd3, 32'd0, 5'd2, 3'd1, 1'b0, 1'b0); step();
      // ex_result beats wb_data for the same register
      ex_rd = 5'd1; ex_result = 32'd77; wb_rd = 5'd1; wb_data = 32'd55;
      instr = enc_r(7'b0000000, 5'd0, 5'd1, 3'b000, 5'd9);
      expect_out("fwd_priority", 5'd9, 32'd77, 32'd0, 5'd0, 3'd0, 1'b0, 1'b0); step();
      wb_en = 1'b0; ex_rd = 5'd0;
      instr = enc_r(7'b0100000, 5'd3, 5'd1, 3'b101, 5'd10);
      expect_out("sra", 5'd10, 32'd55, 32'd0, 5'd5, 3'd5, 1'b1, 1'b0); step();
      instr = enc_i({7'b0100000, 5'd3}, 5'd1, 3'b101, 5'd11);
      expect_out("srai", 5'd11, 32'd55, 32'd0, 5'd3, 3'd5, 1'b1, 1'b0); step();
      instr = enc_i(12'hFFF, 5'd0, 3'b000, 5'd12);
      expect_out("addi_neg", 5'd12, 32'd0, 32'hFFFF_FFFF, 5'd0, 3'd0, 1'b0, 1'b0); step();
      instr = enc_lui(20'hABCDE, 5'd13);
      expect_out("lui", 5'd13, 32'd0, 32'hABCD_E000, 5'd0, 3'd0, 1'b0, 1'b0); step();
   endtask

   task automatic test_back_to_back();
      instr = enc_i(12'd42, 5'd0, 3'b000, 5'd4);
      expect_out("b2b_first", 5'd4, 32'd0, 32'd42, 5'd0, 3'd0, 1'b0, 1'b0); step();
      instr = enc_i(12'd1, 5'd4, 3'b000, 5'd5);
      #1;
      tests_run++;
      if (stall !== 1'b1) begin
         tests_failed++;
         $display("FAIL b2b_stall: stall=%b expected 1", stall);
      end
      expect_bubble("b2b_bubble"); step();
      // EX now presents the result of the first ADDI
      ex_rd = 5'd4; ex_result = 32'd42;
      #1;
      tests_run++;
      if (stall !== 1'b0) begin
         tests_failed++;
         $display("FAIL b2b_release: stall=%b expected 0", stall);
      end
      expect_out("b2b_fwd", 5'd5, 32'd42, 32'd1, 5'd0, 3'd0, 1'b0, 1'b0); step();
   endtask

   task automatic test_memfetch_illegal();
      instr = enc_r(7'b0000000, 5'd0, 5'd6, 3'b000, 5'd8);
      ex_rd = 5'd6; ex_result = 32'hDEAD_BEEF; ex_memfetch = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         tests_run++;
         if (stall !== 1'b1) begin
            tests_failed++;
            $display("FAIL memfetch_stall%0d: stall=%b expected 1", i, stall);
         end
         expect_bubble("memfetch_bubble"); step();
      end
      ex_memfetch = 1'b0; ex_result = 32'd99;
      #1;
      tests_run++;
      if (stall !== 1'b0) begin
         tests_failed++;
         $display("FAIL memfetch_release: stall=%b expected 0", stall);
      end
      expect_out("memfetch_issue", 5'd8, 32'd99, 32'd0, 5'd0, 3'd0, 1'b0, 1'b0); step();
      ex_rd = 5'd0;
      instr = 32'h0000_007F;
      expect_out("illegal", 5'd0, 32'd0, 32'd0, 5'd0, 3'd0, 1'b0, 1'b1); step();
      instr_valid = 1'b0;
      expect_bubble("illegal_pulse_end"); step();
   endtask

   task automatic test_reset_mid_stall();
      instr_valid = 1'b1;
      instr = enc_i(12'd42, 5'd0, 3'b000, 5'd4);
      wb_en = 1'b1; wb_rd = 5'd22; wb_data = 32'd7;
      expect_out("rst_pre", 5'd4, 32'd0, 32'd42, 5'd0, 3'd0, 1'b0, 1'b0); step();
      wb_en = 1'b0;
      instr = enc_i(12'd1, 5'd4, 3'b000, 5'd5);
      #1;
      tests_run++;
      if (stall !== 1'b1) begin
         tests_failed++;
         $display("FAIL rst_stall_before: stall=%b expected 1", stall);
      end
      rst = 1'b1; wb_en = 1'b1; wb_rd = 5'd20; wb_data = 32'd123;
      expect_bubble("rst_mid"); step();
      rst = 1'b0; wb_en = 1'b0;
      #1;
      tests_run++;
      if (stall !== 1'b0) begin
         tests_failed++;
         $display("FAIL rst_stall_after: stall=%b expected 0", stall);
      end
      expect_out("rst_issue", 5'd5, 32'd0, 32'd1, 5'd0, 3'd0, 1'b0, 1'b0); step();
      instr = enc_r(7'b0000000, 5'd22, 5'd20, 3'b000, 5'd21);
      expect_out("rst_cleared", 5'd21, 32'd0, 32'd0, 5'd0, 3'd0, 1'b0, 1'b0); step();
      instr_valid = 1'b0;
   endtask

   initial begin
      test_reset();
      test_alu();
      test_back_to_back();
      test_memfetch_illegal();
      test_reset_mid_stall();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
